// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//  Shares the single-port 48K system RAM between the CPU and the video fetcher.
//  Each requester posts a one-cycle strobe that is latched as a pending request.
//  A three-state FSM (IDLE -> ACC -> DONE) runs one RAM access at a time against
//  a synchronous RAM with one cycle of read latency. Video wins ties unless the
//  CPU has already been passed over MAX_CPU_WAIT times.
//
//  Ports
//   clk, reset            system clock, synchronous active-high reset
//   cpu_req/we/addr/wdata CPU request strobe and its sampled fields
//   cpu_ack, cpu_rdata    CPU completion pulse and held read data
//   cpu_wait_n            low while a CPU access is pending or in flight
//   vid_req, vid_addr     video read strobe and 13-bit offset
//   vid_ack, vid_rdata    video completion pulse and read data
//   mem_addr/we/din       registered RAM command
//   mem_dout              RAM read data, one cycle after mem_addr
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int          MAX_CPU_WAIT = 3,
    parameter logic [15:0] RAM_BASE     = 16'h4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_wait_n,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout
);

    localparam int SW = (MAX_CPU_WAIT < 1) ? 1 : $clog2(MAX_CPU_WAIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_CPU_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic          cpu_pend_r, cpu_we_r;
    logic [15:0]   cpu_addr_r;
    logic [7:0]    cpu_wdata_r;
    logic          vid_pend_r;
    logic [12:0]   vid_addr_r;
    logic          win_cpu_r;
    logic [SW-1:0] starve_r;

    logic grant_s, pick_cpu_s, cpu_accept_s, vid_accept_s, cpu_done_s, vid_done_s;

    // The pending flag covers both the queued and the in-flight phase.
    assign cpu_wait_n = ~cpu_pend_r;

    // Request acceptance and completion decode.
    always_comb begin
        cpu_accept_s = cpu_req && !cpu_pend_r && (cpu_addr >= RAM_BASE);
        vid_accept_s = vid_req && !vid_pend_r;
        cpu_done_s   = (state_r == ST_DONE) && win_cpu_r;
        vid_done_s   = (state_r == ST_DONE) && !win_cpu_r;
    end

    // Next-state logic and winner selection.
    always_comb begin
        state_s    = state_r;
        grant_s    = 1'b0;
        pick_cpu_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_pend_r || vid_pend_r) begin
                    grant_s = 1'b1;
                    state_s = ST_ACC;
                    // Video has priority until the CPU has been starved long enough.
                    if (cpu_pend_r && (!vid_pend_r || (starve_r >= STARVE_MAX))) begin
                        pick_cpu_s = 1'b1;
                    end else begin
                        pick_cpu_s = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC:  state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // CPU request latch; the fields stay frozen while the request is pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_pend_r  <= 1'b0;
            cpu_we_r    <= 1'b0;
            cpu_addr_r  <= 16'h0000;
            cpu_wdata_r <= 8'h00;
        end else if (cpu_accept_s) begin
            cpu_pend_r  <= 1'b1;
            cpu_we_r    <= cpu_we;
            cpu_addr_r  <= cpu_addr;
            cpu_wdata_r <= cpu_wdata;
        end else if (cpu_done_s) begin
            cpu_pend_r  <= 1'b0;
        end
    end

    // Video request latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_pend_r <= 1'b0;
            vid_addr_r <= 13'h0000;
        end else if (vid_accept_s) begin
            vid_pend_r <= 1'b1;
            vid_addr_r <= vid_addr;
        end else if (vid_done_s) begin
            vid_pend_r <= 1'b0;
        end
    end

    // Grant bookkeeping: winner, starvation counter and the RAM command.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cpu_r <= 1'b0;
            starve_r  <= '0;
            mem_addr  <= 16'h0000;
            mem_we    <= 1'b0;
            mem_din   <= 8'h00;
        end else if (grant_s) begin
            win_cpu_r <= pick_cpu_s;
            if (pick_cpu_s) begin
                starve_r <= '0;
                mem_addr <= cpu_addr_r - RAM_BASE;
                mem_we   <= cpu_we_r;
                mem_din  <= cpu_wdata_r;
            end else begin
                // Count only video grants that actually held off a waiting CPU.
                if (cpu_pend_r && (starve_r < STARVE_MAX)) begin
                    starve_r <= starve_r + 1'b1;
                end
                mem_addr <= {3'b000, vid_addr_r};
                mem_we   <= 1'b0;
            end
        end else begin
            mem_we <= 1'b0;
        end
    end

    // Completion: capture read data and pulse the winner's ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_ack   <= 1'b0;
            vid_ack   <= 1'b0;
            cpu_rdata <= 8'h00;
            vid_rdata <= 8'h00;
        end else begin
            cpu_ack <= cpu_done_s;
            vid_ack <= vid_done_s;
            if (cpu_done_s && !cpu_we_r) begin
                cpu_rdata <= mem_dout;
            end
            if (vid_done_s) begin
                vid_rdata <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//  Randomized and directed stimulus against a transaction-level reference
//  model. The model keeps pending flags, a "next free edge" and a plain byte
//  array for the RAM contents; at each grant it pushes the expected RAM
//  command and the expected ack (edge number + data) into queues. A separate
//  monitor pops and compares whenever the DUT presents an ack or a RAM command.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset, cpu_req, cpu_we, vid_req;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [12:0] vid_addr;
    logic        cpu_ack, cpu_wait_n, vid_ack, mem_we;
    logic [7:0]  cpu_rdata, vid_rdata, mem_din, mem_dout;
    logic [15:0] mem_addr;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    function automatic logic [7:0] init_val(int i);
        if (i == 0) return 8'h5A;
        return 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
    endfunction

    // Synchronous RAM with one cycle of read latency.
    logic [7:0] ram [0:49151];
    bit ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 49152; i++) ram[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_din;
        end
        mem_dout <= ram[mem_addr];
    end

    // ------------------------------------------------------------ model
    typedef struct { int cyc; logic [7:0] data; } ack_t;
    typedef struct { int cyc; logic [15:0] addr; logic we; logic [7:0] din; } acc_t;
    ack_t cpu_q[$];
    ack_t vid_q[$];
    acc_t mem_q[$];

    int          cyc = 0;
    bit          m_cpu_pend, m_vid_pend, m_cpu_we, m_win_cpu, mmem_loaded;
    logic [15:0] m_cpu_addr;
    logic [7:0]  m_cpu_wd, m_last_rd;
    logic [12:0] m_vid_addr;
    int          m_grant, m_free_at, m_starve;
    bit          m_busy;
    logic [7:0]  mmem [0:49151];

    task automatic model_step();
        bit          cp, vp, win;
        logic [15:0] a;
        cyc++;
        if (!mmem_loaded) begin
            for (int i = 0; i < 49152; i++) mmem[i] = init_val(i);
            mmem_loaded = 1'b1;
        end
        cp = m_cpu_pend;
        vp = m_vid_pend;
        if (reset) begin
            m_cpu_pend = 0; m_vid_pend = 0; m_busy = 0; m_free_at = 0;
            m_starve = 0; m_last_rd = 8'h00;
            cpu_q.delete(); vid_q.delete(); mem_q.delete();
            return;
        end
        // Completion two edges after the grant releases the requester.
        if (m_busy && cyc == m_grant + 2) begin
            if (m_win_cpu) m_cpu_pend = 0;
            else           m_vid_pend = 0;
            m_busy = 0;
        end
        // One access occupies three edges: grant, access, data.
        if (cyc >= m_free_at && (cp || vp)) begin
            win = cp && (!vp || m_starve >= 3);
            m_grant = cyc; m_free_at = cyc + 3; m_win_cpu = win; m_busy = 1;
            if (win) begin
                m_starve = 0;
                a = m_cpu_addr - 16'h4000;
                if (m_cpu_we) begin
                    mmem[a] = m_cpu_wd;
                    mem_q.push_back(acc_t'{cyc, a, 1'b1, m_cpu_wd});
                    cpu_q.push_back(ack_t'{cyc + 2, m_last_rd});
                end else begin
                    m_last_rd = mmem[a];
                    mem_q.push_back(acc_t'{cyc, a, 1'b0, 8'h00});
                    cpu_q.push_back(ack_t'{cyc + 2, mmem[a]});
                end
            end else begin
                if (cp && m_starve < 3) m_starve++;
                mem_q.push_back(acc_t'{cyc, {3'b000, m_vid_addr}, 1'b0, 8'h00});
                vid_q.push_back(ack_t'{cyc + 2, mmem[{3'b000, m_vid_addr}]});
            end
        end
        if (cpu_req && !cp && cpu_addr >= 16'h4000) begin
            m_cpu_pend = 1; m_cpu_we = cpu_we; m_cpu_addr = cpu_addr; m_cpu_wd = cpu_wdata;
        end
        if (vid_req && !vp) begin
            m_vid_pend = 1; m_vid_addr = vid_addr;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ------------------------------------------------------------ checking
    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: actual %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    initial forever begin
        bit here;
        @(negedge clk);
        if (checking) begin
            chk("cpu_wait_n", {31'd0, cpu_wait_n}, {31'd0, !m_cpu_pend});
            here = cpu_q.size() > 0 && cpu_q[0].cyc == cyc;
            if (here || cpu_ack) begin
                chk("cpu_ack", {31'd0, cpu_ack}, {31'd0, here});
                if (here) begin
                    if (cpu_ack) chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cpu_q[0].data});
                    void'(cpu_q.pop_front());
                end
            end
            here = vid_q.size() > 0 && vid_q[0].cyc == cyc;
            if (here || vid_ack) begin
                chk("vid_ack", {31'd0, vid_ack}, {31'd0, here});
                if (here) begin
                    if (vid_ack) chk("vid_rdata", {24'd0, vid_rdata}, {24'd0, vid_q[0].data});
                    void'(vid_q.pop_front());
                end
            end
            here = mem_q.size() > 0 && mem_q[0].cyc == cyc;
            if (here) begin
                chk("mem_addr", {16'd0, mem_addr}, {16'd0, mem_q[0].addr});
                chk("mem_we", {31'd0, mem_we}, {31'd0, mem_q[0].we});
                if (mem_q[0].we) chk("mem_din", {24'd0, mem_din}, {24'd0, mem_q[0].din});
                void'(mem_q.pop_front());
            end else if (mem_we) begin
                chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic drive(bit cr, bit we, logic [15:0] a, logic [7:0] wd, bit vr, logic [12:0] va);
        @(negedge clk);
        reset = 1'b0; cpu_req = cr; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        vid_req = vr; vid_addr = va;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 13'h0000);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b0; vid_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000;
        cpu_wdata = 8'h00; vid_req = 1'b0; vid_addr = 13'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset values
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_vid_ack", {31'd0, vid_ack}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_wait_n", {31'd0, cpu_wait_n}, 32'd1);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
        chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        chk("rst_vid_rdata", {24'd0, vid_rdata}, 32'd0);
        checking = 1'b1;
        idle(2);

        // CPU read of RAM location 0
        drive(1'b1, 1'b0, 16'h4000, 8'h00, 1'b0, 13'h0000);
        idle(6);
        // Write then read back the top of the CPU window
        drive(1'b1, 1'b1, 16'hFFFF, 8'hC3, 1'b0, 13'h0000);
        idle(5);
        drive(1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 13'h0000);
        idle(6);
        // Simultaneous strobes: video first
        drive(1'b1, 1'b0, 16'h4001, 8'h00, 1'b1, 13'h0005);
        idle(10);
        // Continuous video pressure against a waiting CPU read
        for (int i = 0; i < 40; i++)
            drive(i == 1, 1'b0, 16'h5000, 8'h00, (i % 3) == 0, 13'(i * 7));
        idle(8);
        // Address below the RAM window is discarded
        drive(1'b1, 1'b1, 16'h3FFF, 8'h77, 1'b0, 13'h0000);
        idle(6);
        // Reset while a CPU write is in ACC, then a normal read back
        drive(1'b1, 1'b1, 16'h8000, 8'hA5, 1'b0, 13'h0000);
        idle(1);
        pulse_reset();
        idle(2);
        drive(1'b1, 1'b0, 16'h8000, 8'h00, 1'b0, 13'h0000);
        idle(6);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                drive($urandom_range(0, 3) == 0, 1'($urandom), 16'($urandom),
                      8'($urandom), $urandom_range(0, 2) == 0, 13'($urandom));
            end
        end
        idle(12);
        chk("cpu_q_drained", cpu_q.size(), 32'd0);
        chk("vid_q_drained", vid_q.size(), 32'd0);
        chk("mem_q_drained", mem_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
